// File: rtl/mem_rd_arbiter_pkg.sv
// Shared constants and types for the I/D refill read arbiter.
// Holds FSM encodings, owner IDs and fixed AXI AR attributes.
package mem_rd_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } arb_state_t;

   localparam logic       OWN_I            = 1'b0;
   localparam logic       OWN_D            = 1'b1;
   localparam logic [2:0] AXI_SIZE_8B      = 3'b011;
   localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
   localparam int         DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_rd_arbiter_if.sv
// Signal bundle between the two refill engines, the arbiter and the AXI read channel.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface mem_rd_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64
);
   logic                  ic_req_valid_i, dc_req_valid_i;
   logic                  ic_req_ready_o, dc_req_ready_o;
   logic [ADDR_WIDTH-1:0] ic_req_addr_i,  dc_req_addr_i;
   logic [7:0]            ic_req_len_i,   dc_req_len_i;
   logic                  ic_abort_i;
   logic                  ic_rsp_valid_o, dc_rsp_valid_o;
   logic                  ic_rsp_ready_i, dc_rsp_ready_i;
   logic [DATA_WIDTH-1:0] rsp_data_o;
   logic                  rsp_last_o;
   logic                  rsp_err_o;
   logic                  m_arvalid_o;
   logic                  m_arready_i;
   logic [ADDR_WIDTH-1:0] m_araddr_o;
   logic [7:0]            m_arlen_o;
   logic [2:0]            m_arsize_o;
   logic [1:0]            m_arburst_o;
   logic                  m_arid_o;
   logic                  m_rvalid_i;
   logic                  m_rready_o;
   logic [DATA_WIDTH-1:0] m_rdata_i;
   logic [1:0]            m_rresp_i;
   logic                  m_rlast_i;

   modport master (
      input  ic_req_valid_i, dc_req_valid_i, ic_req_addr_i, dc_req_addr_i,
             ic_req_len_i, dc_req_len_i, ic_abort_i, ic_rsp_ready_i, dc_rsp_ready_i,
             m_arready_i, m_rvalid_i, m_rdata_i, m_rresp_i, m_rlast_i,
      output ic_req_ready_o, dc_req_ready_o, ic_rsp_valid_o, dc_rsp_valid_o,
             rsp_data_o, rsp_last_o, rsp_err_o, m_arvalid_o, m_araddr_o,
             m_arlen_o, m_arsize_o, m_arburst_o, m_arid_o, m_rready_o
   );

   modport slave (
      output ic_req_valid_i, dc_req_valid_i, ic_req_addr_i, dc_req_addr_i,
             ic_req_len_i, dc_req_len_i, ic_abort_i, ic_rsp_ready_i, dc_rsp_ready_i,
             m_arready_i, m_rvalid_i, m_rdata_i, m_rresp_i, m_rlast_i,
      input  ic_req_ready_o, dc_req_ready_o, ic_rsp_valid_o, dc_rsp_valid_o,
             rsp_data_o, rsp_last_o, rsp_err_o, m_arvalid_o, m_araddr_o,
             m_arlen_o, m_arsize_o, m_arburst_o, m_arid_o, m_rready_o
   );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Shares one AXI read channel between I-cache and D-cache refills, one burst at a time.
// D has priority; a starvation counter forces an I grant after STARVE_LIMIT D grants.
module mem_rd_arbiter
   import mem_rd_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 64,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic            clk,
   input  logic            rst,
   mem_rd_arbiter_if.master bus
);
   localparam int SCW = $clog2(STARVE_LIMIT + 1);

   arb_state_t            r_state, w_state_nxt;
   logic                  r_owner;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_len;
   logic                  r_abort;
   logic [SCW-1:0]        r_starve_cnt;

   logic                  w_ic_gnt, w_dc_gnt;
   logic                  w_starved, w_ic_ok;
   logic                  w_abort, w_rready, w_own_rdy;
   logic [DATA_WIDTH-1:0] w_rdata;

   assign w_starved = (r_starve_cnt == SCW'(STARVE_LIMIT));
   assign w_ic_ok   = bus.ic_req_valid_i & ~bus.ic_abort_i;

   // The abort also takes effect in the cycle it is raised, so the beat on the bus then is drained too.
   assign w_abort   = r_abort | ((r_state != ST_IDLE) & (r_owner == OWN_I) & bus.ic_abort_i);
   assign w_own_rdy = (r_owner == OWN_D) ? bus.dc_rsp_ready_i : bus.ic_rsp_ready_i;
   assign w_rready  = (r_state == ST_DATA) & (w_abort | w_own_rdy);
   assign w_rdata   = bus.m_rdata_i;

   always_ff @(posedge clk) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ic_gnt    = 1'b0;
      w_dc_gnt    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (rst) begin
               if (w_ic_ok && (!bus.dc_req_valid_i || w_starved)) w_ic_gnt = 1'b1;
               else if (bus.dc_req_valid_i)                        w_dc_gnt = 1'b1;
            end
            if (w_ic_gnt || w_dc_gnt) w_state_nxt = ST_ADDR;
         end
         ST_ADDR: if (bus.m_arready_i) w_state_nxt = ST_DATA;
         ST_DATA: if (bus.m_rvalid_i && w_rready && bus.m_rlast_i) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_owner      <= OWN_I;
         r_addr       <= '0;
         r_len        <= '0;
         r_abort      <= 1'b0;
         r_starve_cnt <= '0;
      end else begin
         if (w_ic_gnt) begin
            r_owner      <= OWN_I;
            r_addr       <= bus.ic_req_addr_i;
            r_len        <= bus.ic_req_len_i;
            r_starve_cnt <= '0;
         end else if (w_dc_gnt) begin
            r_owner <= OWN_D;
            r_addr  <= bus.dc_req_addr_i;
            r_len   <= bus.dc_req_len_i;
            if (bus.ic_req_valid_i && !w_starved) r_starve_cnt <= r_starve_cnt + SCW'(1);
         end
         if (w_state_nxt == ST_IDLE) r_abort <= 1'b0;
         else if (w_abort)           r_abort <= 1'b1;
      end
   end

   assign bus.ic_req_ready_o = w_ic_gnt;
   assign bus.dc_req_ready_o = w_dc_gnt;

   assign bus.m_arvalid_o = (r_state == ST_ADDR);
   assign bus.m_araddr_o  = r_addr;
   assign bus.m_arlen_o   = r_len;
   assign bus.m_arid_o    = r_owner;
   assign bus.m_arsize_o  = AXI_SIZE_8B;
   assign bus.m_arburst_o = AXI_BURST_INCR;

   assign bus.m_rready_o     = w_rready;
   assign bus.ic_rsp_valid_o = (r_state == ST_DATA) & (r_owner == OWN_I) & bus.m_rvalid_i & ~w_abort;
   assign bus.dc_rsp_valid_o = (r_state == ST_DATA) & (r_owner == OWN_D) & bus.m_rvalid_i;
   assign bus.rsp_data_o     = w_rdata;
   assign bus.rsp_last_o     = bus.m_rlast_i;
   assign bus.rsp_err_o      = bus.m_rresp_i[1];

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter: grant order, starvation, abort, error/backpressure, reset.
module tb_mem_rd_arbiter;
   import mem_rd_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mem_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus();

   mem_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .STARVE_LIMIT(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic ar_accept();
      bus.m_arready_i = 1'b1;
      tick();
      bus.m_arready_i = 1'b0;
   endtask

   task automatic beats(input int n);
      bus.ic_rsp_ready_i = 1'b1;
      bus.dc_rsp_ready_i = 1'b1;
      for (int b = 0; b < n; b++) begin
         bus.m_rvalid_i = 1'b1;
         bus.m_rdata_i  = 64'hB0 + 64'(b);
         bus.m_rlast_i  = (b == n - 1);
         bus.m_rresp_i  = 2'b00;
         tick();
      end
      bus.m_rvalid_i = 1'b0;
      bus.m_rlast_i  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick(); tick();
      n_cmp++; if (dut.r_state !== ST_IDLE) begin n_err++; $display("FAIL rst_state got %0d want %0d", dut.r_state, ST_IDLE); end
      n_cmp++; if (bus.m_arvalid_o !== 1'b0) begin n_err++; $display("FAIL rst_arvalid got %b want 0", bus.m_arvalid_o); end
      n_cmp++; if (bus.m_rready_o !== 1'b0) begin n_err++; $display("FAIL rst_rready got %b want 0", bus.m_rready_o); end
      n_cmp++; if ({bus.ic_req_ready_o, bus.dc_req_ready_o, bus.ic_rsp_valid_o, bus.dc_rsp_valid_o} !== 4'b0000)
         begin n_err++; $display("FAIL rst_rdy_vld got %b want 0000", {bus.ic_req_ready_o, bus.dc_req_ready_o, bus.ic_rsp_valid_o, bus.dc_rsp_valid_o}); end
      n_cmp++; if ({bus.m_araddr_o, bus.m_arlen_o, bus.m_arid_o} !== 41'h0) begin n_err++; $display("FAIL rst_ar_fields got %h want 0", {bus.m_araddr_o, bus.m_arlen_o, bus.m_arid_o}); end
      n_cmp++; if (dut.r_starve_cnt !== 3'd0) begin n_err++; $display("FAIL rst_starve got %0d want 0", dut.r_starve_cnt); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_i_only();
      bus.ic_req_valid_i = 1'b1; bus.ic_req_addr_i = 32'h1000; bus.ic_req_len_i = 8'd3;
      #1;
      n_cmp++; if ({bus.ic_req_ready_o, bus.dc_req_ready_o} !== 2'b10) begin n_err++; $display("FAIL i_grant got %b want 10", {bus.ic_req_ready_o, bus.dc_req_ready_o}); end
      tick();
      bus.ic_req_valid_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         n_cmp++; if ({bus.m_arvalid_o, bus.m_araddr_o, bus.m_arlen_o, bus.m_arid_o} !== {1'b1, 32'h1000, 8'd3, 1'b0})
            begin n_err++; $display("FAIL i_ar_hold c%0d got v%b a%h l%0d id%b want v1 a1000 l3 id0", c, bus.m_arvalid_o, bus.m_araddr_o, bus.m_arlen_o, bus.m_arid_o); end
         if (c < 2) tick();
      end
      n_cmp++; if ({bus.m_arsize_o, bus.m_arburst_o} !== 5'b011_01) begin n_err++; $display("FAIL ar_size_burst got %b want 01101", {bus.m_arsize_o, bus.m_arburst_o}); end
      ar_accept();
      bus.ic_rsp_ready_i = 1'b1;
      for (int b = 0; b < 4; b++) begin
         bus.m_rvalid_i = 1'b1; bus.m_rdata_i = 64'hA0 + 64'(b); bus.m_rlast_i = (b == 3); bus.m_rresp_i = 2'b00;
         #1;
         n_cmp++; if ({bus.ic_rsp_valid_o, bus.dc_rsp_valid_o, bus.m_rready_o, bus.rsp_last_o} !== {3'b101, (b == 3)})
            begin n_err++; $display("FAIL i_beat%0d ivld/dvld/rrdy/last got %b%b%b%b want 101%b", b, bus.ic_rsp_valid_o, bus.dc_rsp_valid_o, bus.m_rready_o, bus.rsp_last_o, (b == 3)); end
         n_cmp++; if (bus.rsp_data_o !== 64'hA0 + 64'(b)) begin n_err++; $display("FAIL i_data%0d got %h want %h", b, bus.rsp_data_o, 64'hA0 + 64'(b)); end
         tick();
      end
      bus.m_rvalid_i = 1'b0; bus.m_rlast_i = 1'b0;
      n_cmp++; if (dut.r_state !== ST_IDLE) begin n_err++; $display("FAIL i_idle_after got %0d want %0d", dut.r_state, ST_IDLE); end
   endtask

   task automatic test_priority();
      bus.ic_req_valid_i = 1'b1; bus.ic_req_addr_i = 32'h2000; bus.ic_req_len_i = 8'd0;
      bus.dc_req_valid_i = 1'b1; bus.dc_req_addr_i = 32'h3000; bus.dc_req_len_i = 8'd1;
      #1;
      n_cmp++; if ({bus.ic_req_ready_o, bus.dc_req_ready_o} !== 2'b01) begin n_err++; $display("FAIL prio_grant got %b want 01", {bus.ic_req_ready_o, bus.dc_req_ready_o}); end
      tick();
      bus.dc_req_valid_i = 1'b0;
      n_cmp++; if ({bus.m_araddr_o, bus.m_arid_o, bus.ic_req_ready_o} !== {32'h3000, 1'b1, 1'b0})
         begin n_err++; $display("FAIL prio_ar_d got a%h id%b irdy%b want a3000 id1 irdy0", bus.m_araddr_o, bus.m_arid_o, bus.ic_req_ready_o); end
      ar_accept();
      bus.dc_rsp_ready_i = 1'b1; bus.m_rvalid_i = 1'b1; bus.m_rlast_i = 1'b0;
      #1;
      n_cmp++; if ({bus.dc_rsp_valid_o, bus.ic_rsp_valid_o} !== 2'b10) begin n_err++; $display("FAIL prio_d_beat got %b want 10", {bus.dc_rsp_valid_o, bus.ic_rsp_valid_o}); end
      tick();
      beats(1);
      #1;
      n_cmp++; if ({bus.ic_req_ready_o, dut.r_starve_cnt} !== {1'b1, 3'd1}) begin n_err++; $display("FAIL prio_i_next got rdy%b cnt%0d want rdy1 cnt1", bus.ic_req_ready_o, dut.r_starve_cnt); end
      tick();
      bus.ic_req_valid_i = 1'b0;
      n_cmp++; if ({bus.m_araddr_o, bus.m_arid_o} !== {32'h2000, 1'b0}) begin n_err++; $display("FAIL prio_ar_i got a%h id%b want a2000 id0", bus.m_araddr_o, bus.m_arid_o); end
      ar_accept();
      beats(1);
   endtask

   task automatic test_starve();
      bus.ic_req_valid_i = 1'b1; bus.ic_req_addr_i = 32'h7000; bus.ic_req_len_i = 8'd0;
      bus.dc_req_valid_i = 1'b1; bus.dc_req_addr_i = 32'h8000; bus.dc_req_len_i = 8'd0;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_cmp++; if ({bus.ic_req_ready_o, bus.dc_req_ready_o, dut.r_starve_cnt} !== {(k == 4), (k != 4), 3'(k)})
            begin n_err++; $display("FAIL starve_k%0d got i%b d%b cnt%0d want i%b d%b cnt%0d", k, bus.ic_req_ready_o, bus.dc_req_ready_o, dut.r_starve_cnt, (k == 4), (k != 4), k); end
         tick();
         n_cmp++; if (bus.m_arid_o !== (k != 4)) begin n_err++; $display("FAIL starve_id%0d got %b want %b", k, bus.m_arid_o, (k != 4)); end
         ar_accept();
         beats(1);
      end
      bus.ic_req_valid_i = 1'b0; bus.dc_req_valid_i = 1'b0;
      n_cmp++; if (dut.r_starve_cnt !== 3'd0) begin n_err++; $display("FAIL starve_clear got %0d want 0", dut.r_starve_cnt); end
   endtask

   task automatic test_abort();
      bus.ic_req_valid_i = 1'b1; bus.ic_abort_i = 1'b1; bus.ic_req_addr_i = 32'h4000; bus.ic_req_len_i = 8'd3;
      #1;
      n_cmp++; if ({bus.ic_req_ready_o, bus.dc_req_ready_o} !== 2'b00) begin n_err++; $display("FAIL abort_idle got %b want 00", {bus.ic_req_ready_o, bus.dc_req_ready_o}); end
      bus.ic_abort_i = 1'b0;
      #1;
      n_cmp++; if (bus.ic_req_ready_o !== 1'b1) begin n_err++; $display("FAIL abort_regrant got %b want 1", bus.ic_req_ready_o); end
      tick();
      bus.ic_req_valid_i = 1'b0;
      ar_accept();
      bus.ic_rsp_ready_i = 1'b1;
      for (int b = 0; b < 4; b++) begin
         bus.m_rvalid_i = 1'b1; bus.m_rlast_i = (b == 3);
         if (b == 1) begin bus.ic_abort_i = 1'b1; bus.ic_rsp_ready_i = 1'b0; end
         #1;
         n_cmp++; if ({bus.ic_rsp_valid_o, bus.m_rready_o} !== {(b == 0), 1'b1})
            begin n_err++; $display("FAIL abort_beat%0d vld/rrdy got %b%b want %b1", b, bus.ic_rsp_valid_o, bus.m_rready_o, (b == 0)); end
         tick();
         bus.ic_abort_i = 1'b0;
      end
      bus.m_rvalid_i = 1'b0; bus.m_rlast_i = 1'b0;
      n_cmp++; if ({dut.r_state, dut.r_abort} !== {ST_IDLE, 1'b0}) begin n_err++; $display("FAIL abort_done got st%0d flag%b want st0 flag0", dut.r_state, dut.r_abort); end
      bus.dc_req_valid_i = 1'b1; bus.dc_req_addr_i = 32'h5000; bus.dc_req_len_i = 8'd0;
      #1;
      n_cmp++; if (bus.dc_req_ready_o !== 1'b1) begin n_err++; $display("FAIL abort_d_grant got %b want 1", bus.dc_req_ready_o); end
      tick();
      bus.dc_req_valid_i = 1'b0;
      ar_accept();
      bus.dc_rsp_ready_i = 1'b1; bus.m_rvalid_i = 1'b1; bus.m_rlast_i = 1'b1;
      #1;
      n_cmp++; if ({bus.dc_rsp_valid_o, bus.m_rready_o} !== 2'b11) begin n_err++; $display("FAIL abort_d_beat got %b want 11", {bus.dc_rsp_valid_o, bus.m_rready_o}); end
      tick();
      bus.m_rvalid_i = 1'b0; bus.m_rlast_i = 1'b0;
   endtask

   task automatic test_err_backpressure();
      int hs = 0;
      bus.dc_req_valid_i = 1'b1; bus.dc_req_addr_i = 32'h6000; bus.dc_req_len_i = 8'd0;
      tick();
      bus.dc_req_valid_i = 1'b0;
      ar_accept();
      bus.dc_rsp_ready_i = 1'b0;
      bus.m_rvalid_i = 1'b1; bus.m_rresp_i = 2'b10; bus.m_rlast_i = 1'b1; bus.m_rdata_i = 64'hDEAD;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) bus.dc_rsp_ready_i = 1'b1;
         #1;
         n_cmp++; if ({bus.m_rready_o, bus.dc_rsp_valid_o, bus.rsp_err_o} !== {(c == 3), 2'b11})
            begin n_err++; $display("FAIL bp_c%0d rrdy/vld/err got %b%b%b want %b11", c, bus.m_rready_o, bus.dc_rsp_valid_o, bus.rsp_err_o, (c == 3)); end
         if (bus.dc_rsp_valid_o && bus.dc_rsp_ready_i) hs++;
         tick();
      end
      bus.m_rvalid_i = 1'b0; bus.m_rlast_i = 1'b0; bus.m_rresp_i = 2'b00;
      n_cmp++; if ({hs[3:0], dut.r_state} !== {4'd1, ST_IDLE}) begin n_err++; $display("FAIL bp_once got hs%0d st%0d want hs1 st0", hs, dut.r_state); end
   endtask

   task automatic test_reset_mid();
      bus.dc_req_valid_i = 1'b1; bus.dc_req_addr_i = 32'h9000; bus.dc_req_len_i = 8'd3;
      tick();
      bus.dc_req_valid_i = 1'b0;
      ar_accept();
      bus.dc_rsp_ready_i = 1'b1; bus.m_rvalid_i = 1'b1; bus.m_rlast_i = 1'b0;
      rst = 1'b0;
      tick();
      n_cmp++; if ({dut.r_state, bus.m_arvalid_o, bus.m_rready_o, bus.dc_rsp_valid_o, bus.dc_req_ready_o} !== {ST_IDLE, 4'b0000})
         begin n_err++; $display("FAIL rstmid got st%0d arv%b rrdy%b dvld%b drdy%b want st0 0000", dut.r_state, bus.m_arvalid_o, bus.m_rready_o, bus.dc_rsp_valid_o, bus.dc_req_ready_o); end
      n_cmp++; if ({bus.m_araddr_o, bus.m_arlen_o, dut.r_starve_cnt} !== 43'h0) begin n_err++; $display("FAIL rstmid_regs got a%h l%0d cnt%0d want 0", bus.m_araddr_o, bus.m_arlen_o, dut.r_starve_cnt); end
      bus.m_rvalid_i = 1'b0;
      rst = 1'b1;
      tick();
   endtask

   initial begin
      bus.ic_req_valid_i = 1'b0; bus.dc_req_valid_i = 1'b0;
      bus.ic_req_addr_i  = '0;   bus.dc_req_addr_i  = '0;
      bus.ic_req_len_i   = '0;   bus.dc_req_len_i   = '0;
      bus.ic_abort_i     = 1'b0;
      bus.ic_rsp_ready_i = 1'b0; bus.dc_rsp_ready_i = 1'b0;
      bus.m_arready_i    = 1'b0; bus.m_rvalid_i     = 1'b0;
      bus.m_rdata_i      = '0;   bus.m_rresp_i      = 2'b00;
      bus.m_rlast_i      = 1'b0;
      @(negedge clk);
      test_reset();
      test_i_only();
      test_priority();
      test_starve();
      test_abort();
      test_err_backpressure();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_rd_arbiter.md
# mem_rd_arbiter

Shares the core's single AXI read channel between the I-cache refill port (I) and the D-cache refill port (D). Only one burst is outstanding at a time. D has priority over I, with a starvation bound that protects fetch. The block sits between the two cache refill engines and the core's AXI master interface. It also lets a fetch flush abandon an in-flight I refill without breaking AXI ordering.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width (matches `ADDR_WIDTH).
- DATA_WIDTH, 64, R-channel data width (matches `XLEN).
- STARVE_LIMIT, 4, maximum consecutive D grants while I is waiting.

Ports:
- clk  in  1  core clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- ic_req_valid_i / dc_req_valid_i  in  1  refill request.
- ic_req_ready_o / dc_req_ready_o  out  1  request accepted this cycle.
- ic_req_addr_i / dc_req_addr_i  in  ADDR_WIDTH  burst start address.
- ic_req_len_i / dc_req_len_i  in  8  AXI burst length (beats − 1).
- ic_abort_i  in  1  IFU flush; discard the current or pending I refill.
- ic_rsp_valid_o / dc_rsp_valid_o  out  1  data beat valid.
- ic_rsp_ready_i / dc_rsp_ready_i  in  1  requester accepts the beat.
- rsp_data_o  out  DATA_WIDTH  shared beat data.
- rsp_last_o  out  1  final beat.
- rsp_err_o  out  1  m_rresp_i[1] for this beat.
- m_arvalid_o  out  1  AXI AR valid.
- m_arready_i  in  1  AXI AR ready.
- m_araddr_o  out  ADDR_WIDTH  AXI AR address.
- m_arlen_o  out  8  AXI AR length.
- m_arsize_o  out  3  AXI AR size.
- m_arburst_o  out  2  AXI AR burst type.
- m_arid_o  out  1  AXI AR ID.
- m_rvalid_i  in  1  AXI R valid.
- m_rready_o  out  1  AXI R ready.
- m_rdata_i  in  DATA_WIDTH  AXI R data.
- m_rresp_i  in  2  AXI R response.
- m_rlast_i  in  1  AXI R last.

## Operation
**FSM:** states IDLE, ADDR, DATA.
- **IDLE:** if any request is valid, grant one.
  - The granted req_ready_o is high combinationally in the same cycle.
  - Address, length and owner are latched; the FSM moves to ADDR.
- **ADDR:** m_arvalid_o = 1 from a register.
  - araddr/arlen/arid are stable until m_arready_i is seen.
  - On handshake the FSM moves to DATA.
- **DATA:** R-channel signals pass through combinationally to the owner.
  - m_rready_o = owner's rsp_ready_i, or 1 when the abort flag is set.
  - owner rsp_valid_o = m_rvalid_i & ~abort.
  - The handshake of the beat with m_rlast_i = 1 returns the FSM to IDLE.

**Arbitration:**
- D wins over I unless starve_cnt == STARVE_LIMIT.
- starve_cnt counts D grants made while ic_req_valid_i = 1.
- starve_cnt clears to 0 on any I grant.
- At the limit, I is granted even if D is valid.

**AXI constants:**
- m_arid_o = 0 for I, 1 for D.
- m_arsize_o = 3'b011 (8 bytes).
- m_arburst_o = INCR (2'b01).

**Abort:**
- ic_abort_i in ADDR or DATA with owner = I sets the abort flag.
  - The AR in flight is still completed; arvalid is never withdrawn.
  - All beats are drained with no ic_rsp_valid_o.
  - The flag clears on return to IDLE.
- ic_abort_i in IDLE forces ic_req_ready_o = 0 that cycle; D may still be granted.
- ic_abort_i with owner = D is ignored.

**Errors:** rsp_err_o is forwarded per beat. The burst still runs to m_rlast_i; the arbiter takes no retry action.

## Timing
- **Reset values:** state = IDLE, m_arvalid_o = 0, m_rready_o = 0, all req_ready_o = 0, all rsp_valid_o = 0, starve_cnt = 0, abort flag = 0, latched address/len/id = 0.
- **Request to AR:** accept in cycle N gives m_arvalid_o high in N+1.
- **AR to data:** arready in cycle N+1 gives DATA in N+2. Beats are forwarded with zero latency.
- **Turnaround:** last beat in cycle M gives IDLE in M+1. A new grant is possible in M+1, with arvalid in M+2.
- **Non-owner:** rsp_valid_o of the non-owner is always 0. Both req_ready_o are 0 outside IDLE.
- **Reset mid-burst:** returns to IDLE immediately. Re-synchronising the AXI slave is the system reset's responsibility.
- **Backpressure:** an owner holding rsp_ready_i low stalls the R channel with no beat lost.

## Structure
- The FSM state encodings, owner IDs, AXI burst/size/resp constants and the default STARVE_LIMIT go as `define entries in Parameters.v.
- Single flat module; no sub-module needed.
- Expected RTL size is about 200 lines.

## Test plan
- I only, addr 0x1000, len 3, arready delayed 2 cycles -> arvalid held with addr 0x1000/arlen 3/arid 0; 4 beats on ic_rsp, rsp_last_o on beat 4; IDLE one cycle after.
- I and D both valid in the same cycle -> D granted (dc_req_ready_o = 1, arid 1); I granted next after D's last beat.
- D valid continuously, I valid, STARVE_LIMIT = 4 -> exactly 4 D bursts, then an I grant, then starve_cnt = 0.
- ic_abort_i mid-DATA on the 2nd of 4 beats -> m_rready_o = 1 for the remaining beats, no ic_rsp_valid_o, next D request served normally.
- Beat with m_rresp_i = 2'b10 and dc_rsp_ready_i low for 3 cycles -> m_rready_o low for those cycles; beat delivered once with rsp_err_o = 1.
- rst low during DATA -> next cycle all outputs at reset values and state IDLE.
